// File: rtl/alu_control_seq.sv
// Registered ALU-control decoder at the ID/EX boundary.
// Adds multi-cycle MUL/DIV occupancy with stall, completion and flush.
module alu_control_seq #(
  parameter int FUNC_W  = 4,
  parameter int OP_W    = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FUNC_W-1:0] in_function,
  input  logic [1:0]        in_aluop,
  input  logic              flush,
  output logic [OP_W-1:0]   alu_op,
  output logic              op_valid,
  output logic              illegal,
  output logic              busy,
  output logic              stall_req,
  output logic              mc_done
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MUL_RLD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_RLD = CNT_W'(DIV_LAT - 1);
  localparam logic MUL_MC = (MUL_LAT > 1);
  localparam logic DIV_MC = (DIV_LAT > 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [OP_W-1:0]  r_alu_op;
  logic [OP_W-1:0]  w_alu_op_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_illegal;
  logic             w_illegal_nxt;

  logic [3:0]       w_code;
  logic             w_dec_ill;
  logic             w_dec_mul;
  logic             w_dec_div;
  logic             w_hi_zero;
  logic             w_cnt_zero;
  logic             w_accept;

  assign w_hi_zero  = ((in_function >> 4) == '0);
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_code    = 4'b0000;
    w_dec_ill = 1'b0;
    w_dec_mul = 1'b0;
    w_dec_div = 1'b0;
    case (in_aluop)
      2'b00: begin
        if (!w_hi_zero) begin
          w_dec_ill = 1'b1;
        end else begin
          case (in_function[3:0])
            4'd0: w_code = 4'b0000;
            4'd1: w_code = 4'b0001;
            4'd2: w_code = 4'b0101;
            4'd3: w_code = 4'b0110;
            4'd4: w_code = 4'b0111;
            4'd5: w_code = 4'b0011;
            4'd6: w_code = 4'b0100;
            4'd7: w_code = 4'b0010;
            4'd8: begin
              w_code    = 4'b1000;
              w_dec_mul = 1'b1;
            end
            4'd9: begin
              w_code    = 4'b1001;
              w_dec_div = 1'b1;
            end
            default: w_dec_ill = 1'b1;
          endcase
        end
      end
      2'b01:   w_code = 4'b0001;
      2'b10:   w_code = 4'b0111;
      default: w_code = 4'b0000;
    endcase
  end

  assign busy      = (r_state == BUSY);
  assign stall_req = busy & ~w_cnt_zero;
  assign mc_done   = busy & w_cnt_zero;
  assign w_accept  = in_valid & ~stall_req & ~flush;

  // Flush outranks both a new accept and an in-flight multi-cycle op.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_alu_op_nxt  = r_alu_op;
    w_valid_nxt   = r_valid;
    w_illegal_nxt = r_illegal;
    if (flush) begin
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_valid_nxt   = 1'b0;
      w_illegal_nxt = 1'b0;
    end else if (w_accept) begin
      w_alu_op_nxt  = OP_W'(w_code);
      w_illegal_nxt = w_dec_ill;
      w_valid_nxt   = 1'b1;
      if (w_dec_mul && MUL_MC) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = MUL_RLD;
      end else if (w_dec_div && DIV_MC) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = DIV_RLD;
      end else begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    end else begin
      case (r_state)
        BUSY: begin
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
          end
        end
        default: w_valid_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_alu_op  <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_alu_op  <= w_alu_op_nxt;
      r_valid   <= w_valid_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  assign alu_op   = r_alu_op;
  assign op_valid = r_valid;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed scoreboard bench for alu_control_seq.
// Expected outputs are queued per step and popped after each edge.
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [5:0] in_function;
  logic [1:0] in_aluop;
  logic       flush;
  logic [3:0] alu_op;
  logic       op_valid;
  logic       illegal;
  logic       busy;
  logic       stall_req;
  logic       mc_done;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] op;
    logic       v;
    logic       ill;
    logic       b;
    logic       s;
    logic       d;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alu_control_seq #(
    .FUNC_W (6),
    .OP_W   (4),
    .MUL_LAT(4),
    .DIV_LAT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_function(in_function),
    .in_aluop   (in_aluop),
    .flush      (flush),
    .alu_op     (alu_op),
    .op_valid   (op_valid),
    .illegal    (illegal),
    .busy       (busy),
    .stall_req  (stall_req),
    .mc_done    (mc_done)
  );

  task automatic cmp(input string tag, input string fld,
                     input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    cmp(tag, "alu_op", alu_op, e.op);
    cmp(tag, "op_valid", {3'b0, op_valid}, {3'b0, e.v});
    cmp(tag, "illegal", {3'b0, illegal}, {3'b0, e.ill});
    cmp(tag, "busy", {3'b0, busy}, {3'b0, e.b});
    cmp(tag, "stall_req", {3'b0, stall_req}, {3'b0, e.s});
    cmp(tag, "mc_done", {3'b0, mc_done}, {3'b0, e.d});
  endtask

  task automatic step(input logic v, input logic [5:0] f,
                      input logic [1:0] a, input logic fl,
                      input logic [3:0] eop, input logic ev,
                      input logic eill, input logic eb,
                      input logic es, input logic ed,
                      input string tag);
    in_valid    = v;
    in_function = f;
    in_aluop    = a;
    flush       = fl;
    q.push_back('{eop, ev, eill, eb, es, ed});
    @(posedge clk);
    #1;
    check(tag);
  endtask

  logic [3:0] tbl [8];

  initial begin
    tbl[0] = 4'b0000; tbl[1] = 4'b0001;
    tbl[2] = 4'b0101; tbl[3] = 4'b0110;
    tbl[4] = 4'b0111; tbl[5] = 4'b0011;
    tbl[6] = 4'b0100; tbl[7] = 4'b0010;

    rst = 1'b1;
    in_valid = 1'b0;
    in_function = '0;
    in_aluop = 2'b00;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.push_back('{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset");
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single-cycle op, then drain
    step(1, 6'd2, 2'b00, 0, 4'b0101, 1, 0, 0, 0, 0, "t1_sub");
    step(0, 6'd0, 2'b00, 0, 4'b0101, 0, 0, 0, 0, 0, "t1_idle");

    // 2: MUL with held follower
    step(1, 6'd8, 2'b00, 0, 4'b1000, 1, 0, 1, 1, 0, "t2_mul1");
    step(1, 6'd0, 2'b01, 0, 4'b1000, 1, 0, 1, 1, 0, "t2_mul2");
    step(1, 6'd0, 2'b01, 0, 4'b1000, 1, 0, 1, 1, 0, "t2_mul3");
    step(1, 6'd0, 2'b01, 0, 4'b1000, 1, 0, 1, 0, 1, "t2_mul4");
    step(1, 6'd0, 2'b01, 0, 4'b0001, 1, 0, 0, 0, 0, "t2_next");
    step(0, 6'd0, 2'b00, 0, 4'b0001, 0, 0, 0, 0, 0, "t2_idle");

    // 3: DIV then MUL back-to-back
    step(1, 6'd9, 2'b00, 0, 4'b1001, 1, 0, 1, 1, 0, "t3_div1");
    for (int i = 2; i <= 7; i++)
      step(1, 6'd8, 2'b00, 0, 4'b1001, 1, 0, 1, 1, 0, "t3_divn");
    step(1, 6'd8, 2'b00, 0, 4'b1001, 1, 0, 1, 0, 1, "t3_div8");
    step(1, 6'd8, 2'b00, 0, 4'b1000, 1, 0, 1, 1, 0, "t3_mul1");
    step(0, 6'd0, 2'b00, 0, 4'b1000, 1, 0, 1, 1, 0, "t3_mul2");
    step(0, 6'd0, 2'b00, 0, 4'b1000, 1, 0, 1, 1, 0, "t3_mul3");
    step(0, 6'd0, 2'b00, 0, 4'b1000, 1, 0, 1, 0, 1, "t3_mul4");
    step(0, 6'd0, 2'b00, 0, 4'b1000, 0, 0, 0, 0, 0, "t3_idle");

    // 4: flush during DIV with a simultaneous instruction
    step(1, 6'd9, 2'b00, 0, 4'b1001, 1, 0, 1, 1, 0, "t4_div1");
    step(0, 6'd0, 2'b00, 0, 4'b1001, 1, 0, 1, 1, 0, "t4_div2");
    step(1, 6'd0, 2'b01, 1, 4'b1001, 0, 0, 0, 0, 0, "t4_flush");
    for (int i = 0; i < 8; i++)
      step(0, 6'd0, 2'b00, 0, 4'b1001, 0, 0, 0, 0, 0, "t4_quiet");

    // 5: illegal functions and ignored function field
    step(1, 6'd12, 2'b00, 0, 4'b0000, 1, 1, 0, 0, 0, "t5_ill12");
    step(1, 6'h22, 2'b00, 0, 4'b0000, 1, 1, 0, 0, 0, "t5_ill22");
    step(1, 6'd12, 2'b10, 0, 4'b0111, 1, 0, 0, 0, 0, "t5_op10");
    step(1, 6'd12, 2'b01, 0, 4'b0001, 1, 0, 0, 0, 0, "t5_op01");
    step(1, 6'd5, 2'b11, 0, 4'b0000, 1, 0, 0, 0, 0, "t5_op11");
    step(1, 6'h12, 2'b00, 0, 4'b0000, 1, 1, 0, 0, 0, "t5_ill12h");
    step(0, 6'd0, 2'b00, 1, 4'b0000, 0, 0, 0, 0, 0, "t5_flush");
    for (int f = 0; f < 8; f++)
      step(1, 6'(f), 2'b00, 0, tbl[f], 1, 0, 0, 0, 0, "t5_tbl");

    // 6: async reset mid-MUL
    step(1, 6'd8, 2'b00, 0, 4'b1000, 1, 0, 1, 1, 0, "t6_mul1");
    step(0, 6'd0, 2'b00, 0, 4'b1000, 1, 0, 1, 1, 0, "t6_mul2");
    #3 rst = 1'b1;
    #1;
    q.push_back('{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("t6_async");
    #2 rst = 1'b0;
    step(1, 6'd0, 2'b00, 0, 4'b0000, 1, 0, 0, 0, 0, "t6_add");
    step(0, 6'd0, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0, "t6_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Parametrised, registered successor to the combinational ALU-control decoder.
- Sits at the ID/EX boundary of the pipelined MIPS. Decodes {ALUOp, function} into an ALU operation code and registers it for EX.
- Adds MUL/DIV multi-cycle operations, with a latency counter, a stall request to the hazard unit, a completion pulse and pipeline flush.

Parameters:
- FUNC_W, 4, width of the function field (>=4; upper bits above bit 3 must be 0 for a legal R-type op).
- OP_W, 4, width of the ALU op code (>=4); codes are zero-extended to this width.
- MUL_LAT, 4, cycles an accepted MUL occupies EX (>=1).
- DIV_LAT, 8, cycles an accepted DIV occupies EX (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a decoded instruction is presented this cycle.
- in_function  in  FUNC_W  R-type function field.
- in_aluop  in  2  ALUOp from main control.
- flush  in  1  synchronous squash of the EX-stage entry.
- alu_op  out  OP_W  registered ALU operation code.
- op_valid  out  1  alu_op holds a live instruction.
- illegal  out  1  registered; the live instruction had an undecodable function.
- busy  out  1  a multi-cycle operation occupies EX.
- stall_req  out  1  upstream must hold its instruction; the ID/EX register must not advance.
- mc_done  out  1  final cycle of a multi-cycle operation.

Behaviour:
- Reset (async, rst=1): alu_op=0, op_valid=0, illegal=0, state=IDLE, cnt=0. Hence busy=0, stall_req=0, mc_done=0. Reset mid-operation aborts it; no mc_done is produced.
- Decode table, with codes zero-extended to OP_W:
  - ALUOp=00 selects by function:
    - 0 -> 0000
    - 1 -> 0001
    - 2 -> 0101
    - 3 -> 0110
    - 4 -> 0111
    - 5 -> 0011
    - 6 -> 0100
    - 7 -> 0010
    - 8 (MUL) -> 1000
    - 9 (DIV) -> 1001
    - any other function -> 0000 with illegal=1
  - ALUOp=01 -> 0001.
  - ALUOp=10 -> 0111.
  - ALUOp=11 -> 0000.
  - Function is ignored for ALUOp != 00.
- Accept condition: accept = in_valid & ~stall_req & ~flush. Latency is 1: decoded values appear on the clock edge after acceptance.
- On an accept edge:
  - alu_op and illegal are loaded; op_valid=1.
  - If the op is MUL with MUL_LAT>1, or DIV with DIV_LAT>1: state goes to BUSY and cnt loads LAT-1.
  - Otherwise state stays or returns to IDLE.
- No accept and no flush: op_valid is cleared unless state=BUSY; alu_op and illegal hold.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, alu_op/op_valid held constant.
    - Each edge with cnt!=0 decrements cnt.
    - mc_done = BUSY & cnt==0 (combinational).
    - stall_req = BUSY & cnt!=0.
- Total occupancy of an accepted MUL in EX is exactly MUL_LAT cycles, and DIV_LAT cycles for DIV. mc_done is high in the last of them.
- Back-to-back issue: in the mc_done cycle stall_req=0, so a presented instruction is accepted on that edge.
  - It becomes live with no bubble.
  - If it is itself multi-cycle, BUSY re-enters with cnt reloaded.
  - Otherwise the edge leaves BUSY for IDLE.
- mc_done cycle with no accept: next edge -> IDLE, op_valid=0.
- LAT=1: the op behaves as single-cycle. BUSY is never entered and mc_done never asserts.
- Flush has priority over accept and over BUSY. On the flush edge:
  - op_valid=0, illegal=0, state=IDLE, cnt=0.
  - alu_op holds.
  - The in-flight multi-cycle op is abandoned without mc_done.
- cnt width is clog2(max(MUL_LAT,DIV_LAT)), minimum 1. Wrap-around is impossible because cnt only decrements while nonzero.
- in_* are ignored while stall_req=1. Upstream holds them, governed by stall_req.

Test Plan:
1. Reset release, then in_valid=1, ALUOp=00, function=2. Next cycle: alu_op=0101, op_valid=1, illegal=0, busy=0. With no further input, one cycle later op_valid=0.
2. ALUOp=00, function=8 (MUL), MUL_LAT=4, next instruction held valid:
   - busy=1 for 4 cycles.
   - stall_req=1 for the first 3 of them.
   - mc_done=1 only in the 4th.
   - The held instruction (ALUOp=01) is accepted on that edge and the next cycle shows alu_op=0001, busy=0.
3. DIV (function=9, DIV_LAT=8), followed immediately by MUL:
   - DIV mc_done in its 8th cycle.
   - MUL accepted on that edge; busy stays 1 with no gap.
   - MUL mc_done 4 cycles later.
4. Flush asserted in the 2nd busy cycle of DIV, simultaneous with in_valid=1. Next cycle: op_valid=0, busy=0, stall_req=0, and mc_done never pulses. The simultaneous instruction is not accepted.
5. Two illegal cases: ALUOp=00 with function=12, and FUNC_W=6 with function=6'h22. Each yields alu_op=0000, illegal=1, op_valid=1. Then ALUOp=10 with function=12 yields alu_op=0111, illegal=0.
6. rst pulsed asynchronously (between edges) mid-MUL. All outputs are 0 immediately. After release, a new ADD (function=0) is accepted normally.
